// File: rtl/enum_index_read_arbiter_if.sv
// Request/response/table-write bundle for enum_index_read_arbiter.
// Optional OOB flag ports are present when ENUM_INDEX_ARB_OOB_FLAG_EN is defined.
interface enum_index_read_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_sel;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
`ifdef ENUM_INDEX_ARB_OOB_FLAG_EN
  logic              rsp_oob;
  logic [15:0]       oob_count;

  modport master (
    output req_valid, req_sel, wr_en, wr_addr, wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_oob, oob_count
  );
  modport slave (
    input  req_valid, req_sel, wr_en, wr_addr, wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_oob, oob_count
  );
`else
  modport master (
    output req_valid, req_sel, wr_en, wr_addr, wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_sel, wr_en, wr_addr, wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/enum_index_read_arbiter.sv
// Round-robin arbiter sharing a 4x DW lookup table, read at clamp(sel+1, 3).
// Optional: ENUM_INDEX_ARB_OOB_FLAG_EN adds rsp_oob and a saturating oob_count.
module enum_index_read_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned IDW  = 3
) (
  input  logic clk,
  input  logic rst_n,
  enum_index_read_arbiter_if.slave bus
);
  localparam int unsigned NSLOT   = 1 << IDW;
  localparam int unsigned ENTRIES = 4;

  logic [DW-1:0]    tbl [ENTRIES];
  logic [IDW-1:0]   ptr_q;
  logic [NSLOT-1:0] valid_ext;
  logic [1:0]       sel_arr [NSLOT];
  logic             can_accept;
  logic             found;
  logic             xfer;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_sel;
  logic [2:0]       idx_raw;
  logic [1:0]       idx;

  // Pad requester vectors to the full id space so ids index them exactly.
  always_comb begin
    valid_ext = NSLOT'(bus.req_valid);
    for (int unsigned i = 0; i < NSLOT; i++) sel_arr[i] = 2'd0;
    for (int unsigned i = 0; i < NREQ; i++) sel_arr[i] = bus.req_sel[2*i +: 2];
  end

  // Search from the pointer upward, wrapping at NREQ; first valid wins.
  always_comb begin
    can_accept    = !bus.rsp_valid || bus.rsp_ready;
    found         = 1'b0;
    win_id        = '0;
    cand          = '0;
    bus.req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && valid_ext[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    xfer = found && can_accept && rst_n;
    if (xfer) bus.req_ready = NREQ'(1) << win_id;
  end

  assign win_sel = sel_arr[win_id];
  assign idx_raw = {1'b0, win_sel} + 3'd1;
  assign idx     = (idx_raw > 3'd3) ? 2'd3 : idx_raw[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) tbl[i] <= '0;
    end else if (bus.wr_en) begin
      tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Single-entry output register; a grant replaces a draining response in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      ptr_q         <= '0;
    end else if (xfer) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= win_id;
      bus.rsp_data  <= tbl[idx];
      ptr_q         <= IDW'((32'(win_id) + 32'd1) % NREQ);
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

`ifdef ENUM_INDEX_ARB_OOB_FLAG_EN
  logic [15:0] oob_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_oob <= 1'b0;
      oob_cnt_q   <= '0;
    end else if (xfer) begin
      bus.rsp_oob <= idx_raw[2];
      if (idx_raw[2] && (oob_cnt_q != 16'hFFFF)) oob_cnt_q <= oob_cnt_q + 16'd1;
    end
  end

  assign bus.oob_count = oob_cnt_q;
`endif
endmodule
